// File: rtl/mrd_feeder_pkg.sv
// mrd_feeder_pkg: shared types and sizing helpers for the 2-lane DFT frame feeder.
package mrd_feeder_pkg;
  localparam int DW_DEF = 18;
  typedef enum logic [1:0] {IDLE, WAIT_RDY, STREAM, GAP} feeder_st_t;
  function automatic int gap_w(int gap_cycles);
    return $clog2(gap_cycles + 1);
  endfunction
  function automatic int beat_w(int pts_w);
    return pts_w - 1;
  endfunction
endpackage

// File: rtl/mrd_frame_feeder_p2_if.sv
// mrd_frame_feeder_p2_if: upstream sample stream and DFT sink port; master is the feeder side.
interface mrd_frame_feeder_p2_if
  import mrd_feeder_pkg::*;
#(parameter int DW = DW_DEF);
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] up_real [0:1];
  logic [DW-1:0] up_imag [0:1];
  logic          sink_valid;
  logic          sink_ready;
  logic          sink_sop;
  logic          sink_eop;
  logic [DW-1:0] sink_real [0:1];
  logic [DW-1:0] sink_imag [0:1];
  modport master (
    input  up_valid, up_real, up_imag, sink_ready,
    output up_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag
  );
  modport slave (
    output up_valid, up_real, up_imag, sink_ready,
    input  up_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag
  );
endinterface

// File: rtl/mrd_feeder_stats.sv
// mrd_feeder_stats: frame counter (wrapping) and per-frame bubble counter (saturating).
module mrd_feeder_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        frame,
  input  logic        bubble,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_bubbles
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames  <= '0;
      stat_bubbles <= '0;
    end else begin
      stat_frames  <= stat_frames + 16'(frame);
      stat_bubbles <= clr ? '0 : (bubble && stat_bubbles != 16'hFFFF) ? stat_bubbles + 16'd1 : stat_bubbles;
    end
  end
endmodule

// File: rtl/mrd_frame_feeder_p2.sv
// mrd_frame_feeder_p2: cuts a 2-lane sample stream into DFT frames with sop/eop and post-frame gap.
// Optional statistics outputs enabled by MRD_FEEDER_STATS_EN.
module mrd_frame_feeder_p2
  import mrd_feeder_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int PTS_W      = 12,
  parameter int GAP_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [PTS_W-1:0] cfg_pts,
  input  logic [5:0]       cfg_size,
  input  logic             cfg_inverse,
  output logic             cfg_err,
  output logic             busy,
  output logic             frame_done,
  output logic [5:0]       size,
  output logic             inverse,
  mrd_frame_feeder_p2_if.master bus
`ifdef MRD_FEEDER_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_bubbles
`endif
);
  localparam int BW = beat_w(PTS_W);
  localparam int GW = gap_w(GAP_CYCLES);
  feeder_st_t st, st_n;
  logic [BW-1:0] beats, cnt;
  logic [GW-1:0] gap_cnt;
  logic legal, start, accept, last;
  assign legal  = !cfg_pts[0] && cfg_pts != '0;
  assign start  = st == IDLE && cfg_start && legal;
  assign accept = st == STREAM && bus.up_valid;
  assign last   = cnt == beats - 1'b1;
  always_comb begin
    st_n = st;
    if (start) st_n = WAIT_RDY;
    if (st == WAIT_RDY && bus.sink_ready) st_n = STREAM;
    if (accept && last) st_n = GAP;
    if (st == GAP && gap_cnt == GW'(GAP_CYCLES)) st_n = IDLE;
    busy         = st != IDLE;
    bus.up_ready = st == STREAM;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err        <= 1'b0;
      frame_done     <= 1'b0;
      size           <= '0;
      inverse        <= 1'b0;
      beats          <= '0;
      cnt            <= '0;
      gap_cnt        <= '0;
      bus.sink_valid <= 1'b0;
      bus.sink_sop   <= 1'b0;
      bus.sink_eop   <= 1'b0;
      bus.sink_real  <= '{default: '0};
      bus.sink_imag  <= '{default: '0};
    end else begin
      cfg_err        <= cfg_start && (st != IDLE || !legal);
      frame_done     <= accept && last;
      bus.sink_valid <= accept;
      bus.sink_sop   <= accept && cnt == '0;
      bus.sink_eop   <= accept && last;
      gap_cnt        <= st == GAP ? gap_cnt + 1'b1 : '0;
      if (start) begin
        beats   <= cfg_pts[PTS_W-1:1];
        size    <= cfg_size;
        inverse <= cfg_inverse;
        cnt     <= '0;
      end
      // data registers only load on accepted beats so they hold across bubbles
      if (accept) begin
        cnt           <= cnt + 1'b1;
        bus.sink_real <= bus.up_real;
        bus.sink_imag <= bus.up_imag;
      end
    end
  end
`ifdef MRD_FEEDER_STATS_EN
  mrd_feeder_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .clr          (start),
    .frame        (accept && last),
    .bubble       (st == STREAM && !bus.up_valid),
    .stat_frames  (stat_frames),
    .stat_bubbles (stat_bubbles)
  );
`endif
endmodule
